// File: rtl/pattern_stream_detector.sv
// Multi-channel streaming pattern detector: per-channel sliding-window compare
// across beat boundaries, lowest-offset report, consecutive-match alarm and a
// saturating global match counter. Two-stage pipeline (hit vector, then encode).
module pattern_stream_detector #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned PAT_W  = 32,
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned TH_W   = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_wr,
  input  logic                       cfg_mode,
  input  logic [PAT_W-1:0]           cfg_pattern,
  input  logic [PAT_W-1:0]           cfg_mask,
  input  logic [TH_W-1:0]            cfg_thresh,
  input  logic                       det_en,
  input  logic                       clr,
  input  logic [NUM_CH-1:0]          in_valid,
  input  logic [NUM_CH*DATA_W-1:0]   in_data,
  output logic [NUM_CH-1:0]          match_valid,
  output logic [NUM_CH*$clog2(DATA_W+PAT_W)-1:0] match_offset,
  output logic [NUM_CH-1:0]          alarm,
  output logic [CNT_W-1:0]           match_count
);

  localparam int unsigned OFF_W  = $clog2(DATA_W + PAT_W);
  localparam int unsigned HIST_W = PAT_W - 1;
  localparam int unsigned VEC_W  = DATA_W + HIST_W;

  // Latched configuration
  logic                cfg_mode_q;
  logic [PAT_W-1:0]    cfg_pattern_q;
  logic [PAT_W-1:0]    cfg_mask_q;
  logic [TH_W-1:0]     cfg_thresh_q;

  // Per-channel history and pipeline state
  logic [NUM_CH-1:0][HIST_W-1:0] hist_q;
  logic [NUM_CH-1:0]             hist_vld_q;
  logic [NUM_CH-1:0][DATA_W-1:0] s1_hit_q;
  logic [NUM_CH-1:0]             s1_vld_q;
  logic [NUM_CH-1:0][TH_W-1:0]   consec_q;

  // Combinational intermediates
  logic                          flush;
  logic [NUM_CH-1:0]             accept;
  logic [VEC_W-1:0]              vec;
  logic [PAT_W-1:0]              win;
  logic                          eq;
  logic [NUM_CH-1:0][DATA_W-1:0] hit_c;
  logic [NUM_CH-1:0][OFF_W-1:0]  enc_c;
  logic [NUM_CH-1:0]             found;
  logic [TH_W-1:0]               th_eff;
  logic [NUM_CH-1:0]             mv_next;
  logic [NUM_CH*OFF_W-1:0]       off_next;
  logic [NUM_CH-1:0][TH_W-1:0]   consec_next;
  logic [NUM_CH-1:0]             alarm_next;
  logic [CNT_W:0]                sum;
  logic [CNT_W-1:0]              count_next;

  assign flush  = cfg_wr | clr;
  assign accept = in_valid & {NUM_CH{det_en & ~cfg_wr & ~clr}};
  assign th_eff = (cfg_thresh_q == '0) ? TH_W'(1) : cfg_thresh_q;

  // Stage-1 window compare: one hit bit per window k; history windows gated when stale
  always_comb begin
    vec   = '0;
    win   = '0;
    eq    = 1'b0;
    hit_c = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      vec = {in_data[c*DATA_W +: DATA_W], hist_q[c]};
      for (int unsigned k = 0; k < DATA_W; k++) begin
        win = vec[k +: PAT_W];
        if (cfg_mode_q) eq = (((win ^ cfg_pattern_q) & cfg_mask_q) == '0);
        else            eq = (win == cfg_pattern_q);
        if ((k >= HIST_W) || hist_vld_q[c]) hit_c[c][k] = eq;
      end
    end
  end

  // Lowest-index priority encoder per channel
  always_comb begin
    enc_c = '0;
    found = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      for (int unsigned k = 0; k < DATA_W; k++) begin
        if (!found[c] && s1_hit_q[c][k]) begin
          enc_c[c] = OFF_W'(k);
          found[c] = 1'b1;
        end
      end
    end
  end

  // Stage-2 next state: match pulse, offset, consecutive counter, alarm, global count
  always_comb begin
    mv_next     = '0;
    off_next    = match_offset;
    consec_next = consec_q;
    alarm_next  = alarm;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (s1_vld_q[c]) begin
        if (|s1_hit_q[c]) begin
          mv_next[c] = 1'b1;
          off_next[c*OFF_W +: OFF_W] = enc_c[c];
          if (consec_q[c] < th_eff) consec_next[c] = consec_q[c] + TH_W'(1);
          if (consec_next[c] == th_eff) alarm_next[c] = 1'b1;
        end else begin
          consec_next[c] = '0;
        end
      end
    end
    sum = {1'b0, match_count};
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      sum = sum + (CNT_W+1)'(mv_next[c]);
    end
    count_next = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  end

  // Configuration registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_mode_q    <= 1'b0;
      cfg_pattern_q <= '0;
      cfg_mask_q    <= '0;
      cfg_thresh_q  <= TH_W'(1);
    end else if (cfg_wr) begin
      cfg_mode_q    <= cfg_mode;
      cfg_pattern_q <= cfg_pattern;
      cfg_mask_q    <= cfg_mask;
      cfg_thresh_q  <= cfg_thresh;
    end
  end

  // History capture and stage-1 pipeline registers
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q     <= '0;
      hist_vld_q <= '0;
      s1_hit_q   <= '0;
      s1_vld_q   <= '0;
    end else begin
      s1_hit_q <= hit_c;
      s1_vld_q <= flush ? '0 : accept;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (flush) begin
          hist_q[c]     <= '0;
          hist_vld_q[c] <= 1'b0;
        end else if (accept[c]) begin
          hist_q[c]     <= in_data[c*DATA_W + (DATA_W - HIST_W) +: HIST_W];
          hist_vld_q[c] <= 1'b1;
        end
      end
    end
  end

  // Stage-2 output registers; flush suppresses in-flight results
  always_ff @(posedge clk) begin
    if (rst) begin
      match_valid  <= '0;
      match_offset <= '0;
      consec_q     <= '0;
      alarm        <= '0;
    end else if (flush) begin
      match_valid  <= '0;
      consec_q     <= '0;
      alarm        <= '0;
    end else begin
      match_valid  <= mv_next;
      match_offset <= off_next;
      consec_q     <= consec_next;
      alarm        <= alarm_next;
    end
  end

  // Global saturating match counter; survives cfg_wr, cleared by clr
  always_ff @(posedge clk) begin
    if (rst || clr)   match_count <= '0;
    else if (!cfg_wr) match_count <= count_next;
  end

endmodule

// File: tb/tb_pattern_stream_detector.sv
// Directed bench for pattern_stream_detector: exact/masked compare, straddling
// patterns, threshold alarm, counter saturation (CNT_W=4 copy) and flush.
module tb_pattern_stream_detector;

  logic          clk;
  logic          rst;
  logic          cfg_wr;
  logic          cfg_mode;
  logic [31:0]   cfg_pattern;
  logic [31:0]   cfg_mask;
  logic [3:0]    cfg_thresh;
  logic          det_en;
  logic          clr;
  logic [1:0]    in_valid;
  logic [127:0]  in_data;

  logic [1:0]    match_valid;
  logic [13:0]   match_offset;
  logic [1:0]    alarm;
  logic [15:0]   match_count;

  logic [1:0]    s_match_valid;
  logic [13:0]   s_match_offset;
  logic [1:0]    s_alarm;
  logic [3:0]    s_match_count;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] D_EXACT = 64'h0000_0000_DEAD_BEEF;

  pattern_stream_detector dut (
    .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_mode(cfg_mode),
    .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask), .cfg_thresh(cfg_thresh),
    .det_en(det_en), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .match_valid(match_valid), .match_offset(match_offset),
    .alarm(alarm), .match_count(match_count)
  );

  pattern_stream_detector #(.CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_mode(cfg_mode),
    .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask), .cfg_thresh(cfg_thresh),
    .det_en(det_en), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .match_valid(s_match_valid), .match_offset(s_match_offset),
    .alarm(s_alarm), .match_count(s_match_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [1:0] v, input logic [63:0] d0, input logic [63:0] d1);
    in_valid = v;
    in_data  = {d1, d0};
    tick();
    in_valid = 2'b00;
  endtask

  task automatic cfg(input logic m, input logic [31:0] p, input logic [31:0] k, input logic [3:0] th);
    cfg_wr = 1'b1; cfg_mode = m; cfg_pattern = p; cfg_mask = k; cfg_thresh = th;
    tick();
    cfg_wr = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cfg_wr = 1'b0; cfg_mode = 1'b0; cfg_pattern = '0; cfg_mask = '0;
    cfg_thresh = 4'd1; det_en = 1'b0; clr = 1'b0; in_valid = '0; in_data = '0;
    tick(); tick();
    chk("rst_mv", 64'(match_valid), 64'd0);
    chk("rst_off", 64'(match_offset), 64'd0);
    chk("rst_alarm", 64'(alarm), 64'd0);
    chk("rst_count", 64'(match_count), 64'd0);
    rst = 1'b0;
    det_en = 1'b1;

    // 1. exact match on first beat, offset 47, two-cycle latency
    cfg(1'b0, 32'hDEAD_BEEF, 32'h0, 4'd1);
    beat(2'b01, 64'h0000_DEAD_BEEF_0000, 64'h0);
    chk("t1_lat_mv", 64'(match_valid), 64'd0);
    tick();
    chk("t1_mv", 64'(match_valid), 64'b01);
    chk("t1_off", 64'(match_offset[6:0]), 64'd47);
    chk("t1_count", 64'(match_count), 64'd1);
    chk("t1_alarm", 64'(alarm), 64'b01);
    tick();
    chk("t1_pulse", 64'(match_valid), 64'd0);
    chk("t1_hold_off", 64'(match_offset[6:0]), 64'd47);

    // 2. straddling pattern, then the same with clr in between
    pulse_clr();
    beat(2'b01, 64'hBEEF_0000_0000_0000, 64'h0);
    beat(2'b01, 64'h0000_0000_0000_DEAD, 64'h0);
    chk("t2_a_mv", 64'(match_valid), 64'd0);
    tick();
    chk("t2_b_mv", 64'(match_valid), 64'b01);
    chk("t2_b_off", 64'(match_offset[6:0]), 64'd15);
    chk("t2_count", 64'(match_count), 64'd1);
    pulse_clr();
    beat(2'b01, 64'hBEEF_0000_0000_0000, 64'h0);
    pulse_clr();
    beat(2'b01, 64'h0000_0000_0000_DEAD, 64'h0);
    tick();
    chk("t2_clr_mv", 64'(match_valid), 64'd0);
    chk("t2_clr_count", 64'(match_count), 64'd0);

    // 3. masked compare vs exact compare on the same data
    cfg(1'b1, 32'h1234_0000, 32'hFFFF_0000, 4'd1);
    beat(2'b01, 64'h0, 64'h0);
    beat(2'b01, 64'h0000_0000_1234_5678, 64'h0);
    chk("t3_zero_mv", 64'(match_valid), 64'd0);
    tick();
    chk("t3_mask_mv", 64'(match_valid), 64'b01);
    chk("t3_mask_off", 64'(match_offset[6:0]), 64'd31);
    cfg(1'b0, 32'h1234_0000, 32'hFFFF_0000, 4'd1);
    beat(2'b01, 64'h0, 64'h0);
    beat(2'b01, 64'h0000_0000_1234_5678, 64'h0);
    tick();
    chk("t3_exact_mv", 64'(match_valid), 64'd0);

    // 4. threshold 3 on ch1 with gaps, then restart after a miss
    cfg(1'b0, 32'hDEAD_BEEF, 32'h0, 4'd3);
    beat(2'b10, 64'h0, D_EXACT); tick();
    chk("t4_m1_mv", 64'(match_valid), 64'b10);
    chk("t4_m1_alarm", 64'(alarm), 64'd0);
    tick();
    beat(2'b10, 64'h0, D_EXACT); tick();
    chk("t4_m2_alarm", 64'(alarm), 64'd0);
    tick();
    beat(2'b10, 64'h0, D_EXACT); tick();
    chk("t4_m3_mv", 64'(match_valid), 64'b10);
    chk("t4_m3_off", 64'(match_offset[13:7]), 64'd31);
    chk("t4_m3_alarm", 64'(alarm), 64'b10);
    tick(); tick();
    chk("t4_sticky", 64'(alarm), 64'b10);
    cfg(1'b0, 32'hDEAD_BEEF, 32'h0, 4'd3);
    chk("t4_cfg_clr_alarm", 64'(alarm), 64'd0);
    beat(2'b10, 64'h0, D_EXACT);
    beat(2'b10, 64'h0, D_EXACT);
    beat(2'b10, 64'h0, 64'h0);
    beat(2'b10, 64'h0, D_EXACT);
    beat(2'b10, 64'h0, D_EXACT);
    tick();
    chk("t4_restart_mv", 64'(match_valid), 64'b10);
    chk("t4_restart_alarm", 64'(alarm), 64'd0);
    beat(2'b10, 64'h0, D_EXACT); tick();
    chk("t4_restart_hit", 64'(alarm), 64'b10);

    // 5. dual-channel increment and saturation of the 4-bit counter copy
    pulse_clr();
    beat(2'b11, D_EXACT, D_EXACT); tick();
    chk("t5_mv", 64'(match_valid), 64'b11);
    chk("t5_count2", 64'(match_count), 64'd2);
    chk("t5_s_count2", 64'(s_match_count), 64'd2);
    for (int i = 0; i < 9; i++) beat(2'b11, D_EXACT, D_EXACT);
    tick(); tick();
    chk("t5_count20", 64'(match_count), 64'd20);
    chk("t5_s_sat", 64'(s_match_count), 64'd15);

    // 6. flush: cfg_wr kills in-flight beat, drops its own beat, stales history
    cfg(1'b0, 32'hDEAD_BEEF, 32'h0, 4'd1);
    chk("t6_cfg_keeps_count", 64'(match_count), 64'd20);
    beat(2'b01, D_EXACT, 64'h0);
    cfg_wr = 1'b1; cfg_mode = 1'b0; cfg_pattern = 32'hDEAD_0000; cfg_mask = '0; cfg_thresh = 4'd1;
    in_valid = 2'b01; in_data = {64'h0, 64'h0000_0000_0000_DEAD};
    tick();
    cfg_wr = 1'b0; in_valid = 2'b00;
    chk("t6_flush_mv", 64'(match_valid), 64'd0);
    chk("t6_flush_alarm", 64'(alarm), 64'd0);
    beat(2'b01, 64'h0000_0000_0000_DEAD, 64'h0);
    chk("t6_drop_mv", 64'(match_valid), 64'd0);
    tick();
    chk("t6_hist_gate_mv", 64'(match_valid), 64'd0);
    beat(2'b01, 64'h0000_0000_0000_DEAD, 64'h0); tick();
    chk("t6_hist_ok_mv", 64'(match_valid), 64'b01);
    chk("t6_hist_ok_off", 64'(match_offset[6:0]), 64'd15);
    chk("t6_count", 64'(match_count), 64'd21);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
